// File: rtl/csr_timer_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : csr_timer_pkg
//  Description : Shared constants for the timer/counter CSR group:
//                CSR addresses owned by csr_timer, TCFG/TICLR field
//                positions and the masked-write helper.
//  Ports       : none (package)
//  Revision    : 1.0 - initial release
// ============================================================================
package csr_timer_pkg;

    // CSR addresses owned by the timer group
    localparam logic [13:0] CSR_TID   = 14'h040;
    localparam logic [13:0] CSR_TCFG  = 14'h041;
    localparam logic [13:0] CSR_TVAL  = 14'h042;
    localparam logic [13:0] CSR_TICLR = 14'h044;

    // TCFG field positions
    localparam int CSR_TCFG_EN         = 0;
    localparam int CSR_TCFG_PERIOD     = 1;
    localparam int CSR_TCFG_INITV_LSB  = 2;
    localparam int CSR_TCFG_INITV_MSB  = 31;

    // TICLR field position
    localparam int CSR_TICLR_CLR       = 0;

    // Value at which an expired one-shot timer parks
    localparam logic [31:0] TVAL_PARK  = 32'hFFFF_FFFF;

    // Bitwise masked write: masked bits take the new value, the rest hold
    function automatic logic [31:0] mask_merge(
        input logic [31:0] old_val,
        input logic [31:0] wmask,
        input logic [31:0] wvalue
    );
        return (wmask & wvalue) | (~wmask & old_val);
    endfunction

endpackage
`default_nettype wire

// File: rtl/csr_timer_stable_counter.sv
`default_nettype none
// ============================================================================
//  Module      : stable_counter
//  Description : Free-running W-bit counter, asynchronously cleared, exposed
//                as a zero-extended 64-bit value split into hi/lo halves.
//  Ports       : clk     - clock
//                resetn  - asynchronous active-low reset
//                cnt_lo  - counter bits [31:0]
//                cnt_hi  - counter bits [63:32]
//  Revision    : 1.0 - initial release
// ============================================================================
module stable_counter #(
    parameter int W = 64
) (
    input  logic        clk,
    input  logic        resetn,
    output logic [31:0] cnt_lo,
    output logic [31:0] cnt_hi
);

    logic [W-1:0] r_cnt;
    logic [63:0]  w_ext;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + {{(W-1){1'b0}}, 1'b1};
        end
    end

    // Narrow builds (bench shortening) are zero-extended to the 64-bit view
    generate
        if (W >= 64) begin : g_full_width
            assign w_ext = r_cnt[63:0];
        end else begin : g_narrow_width
            assign w_ext = {{(64-W){1'b0}}, r_cnt};
        end
    endgenerate

    assign cnt_lo = w_ext[31:0];
    assign cnt_hi = w_ext[63:32];

endmodule
`default_nettype wire

// File: rtl/csr_timer.sv
`default_nettype none
// ============================================================================
//  Module      : csr_timer
//  Description : Timer/counter CSR group. Hosts TID, TCFG, TVAL, TICLR, the
//                sticky timer interrupt flag and the 64-bit stable counter.
//  Ports       : clk, resetn            - clock / async active-low reset
//                csr_we, csr_num,
//                csr_wmask, csr_wvalue  - CSR instruction access bus
//                timer_hit              - csr_num addresses this block
//                timer_rvalue           - read data for owned addresses
//                timer_int              - pending timer interrupt (ESTAT.IS[11])
//                cnt_vl, cnt_vh         - stable counter low/high words
//                tid                    - current TID value
//  Revision    : 1.0 - initial release
// ============================================================================
module csr_timer
    import csr_timer_pkg::*;
#(
    parameter logic [31:0] TID_RESET = 32'h0,
    parameter int          CNT_W     = 64
) (
    input  logic        clk,
    input  logic        resetn,
    input  logic        csr_we,
    input  logic [13:0] csr_num,
    input  logic [31:0] csr_wmask,
    input  logic [31:0] csr_wvalue,
    output logic        timer_hit,
    output logic [31:0] timer_rvalue,
    output logic        timer_int,
    output logic [31:0] cnt_vl,
    output logic [31:0] cnt_vh,
    output logic [31:0] tid
);

    logic [31:0] r_tid;
    logic [31:0] r_tcfg;
    logic [31:0] r_tval;
    logic        r_timer_int;

    logic        w_tid_we;
    logic        w_tcfg_we;
    logic        w_ticlr_we;
    logic [31:0] w_tcfg_new;
    logic [31:0] w_tcfg_next;
    logic [31:0] w_reload;
    logic [31:0] w_tval_next;
    logic        w_int_set;
    logic        w_int_clr;

    assign w_tid_we   = csr_we && (csr_num == CSR_TID);
    assign w_tcfg_we  = csr_we && (csr_num == CSR_TCFG);
    assign w_ticlr_we = csr_we && (csr_num == CSR_TICLR);

    assign w_tcfg_new  = mask_merge(r_tcfg, csr_wmask, csr_wvalue);
    assign w_tcfg_next = w_tcfg_we ? w_tcfg_new : r_tcfg;

    // Reload value always comes from the config that will be in force
    // next cycle, so a TCFG write loads its own InitVal.
    assign w_reload = {w_tcfg_next[CSR_TCFG_INITV_MSB:CSR_TCFG_INITV_LSB], 2'b00};

    // Countdown priority: enabling write > periodic reload > decrement > hold.
    // Using the post-write En means a write that clears En freezes TVAL
    // at its present value rather than letting it tick once more.
    always_comb begin
        w_tval_next = r_tval;
        if (w_tcfg_we && w_tcfg_new[CSR_TCFG_EN]) begin
            w_tval_next = w_reload;
        end else if (w_tcfg_next[CSR_TCFG_EN] && (r_tval == 32'h0)
                     && w_tcfg_next[CSR_TCFG_PERIOD]) begin
            w_tval_next = w_reload;
        end else if (w_tcfg_next[CSR_TCFG_EN] && (r_tval != TVAL_PARK)) begin
            w_tval_next = r_tval - 32'h1;
        end
    end

    assign w_int_set = r_tcfg[CSR_TCFG_EN] && (r_tval == 32'h0);
    assign w_int_clr = w_ticlr_we && csr_wmask[CSR_TICLR_CLR]
                       && csr_wvalue[CSR_TICLR_CLR];

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_tid       <= TID_RESET;
            r_tcfg      <= 32'h0;
            r_tval      <= TVAL_PARK;
            r_timer_int <= 1'b0;
        end else begin
            if (w_tid_we) begin
                r_tid <= mask_merge(r_tid, csr_wmask, csr_wvalue);
            end
            r_tcfg <= w_tcfg_next;
            r_tval <= w_tval_next;
            // Set has priority over clear so an expiry is never lost
            if (w_int_set) begin
                r_timer_int <= 1'b1;
            end else if (w_int_clr) begin
                r_timer_int <= 1'b0;
            end
        end
    end

    // Read mux: purely combinational, no read side effects
    always_comb begin
        timer_hit    = 1'b0;
        timer_rvalue = 32'h0;
        case (csr_num)
            CSR_TID: begin
                timer_hit    = 1'b1;
                timer_rvalue = r_tid;
            end
            CSR_TCFG: begin
                timer_hit    = 1'b1;
                timer_rvalue = r_tcfg;
            end
            CSR_TVAL: begin
                timer_hit    = 1'b1;
                timer_rvalue = r_tval;
            end
            CSR_TICLR: begin
                timer_hit    = 1'b1;
                timer_rvalue = 32'h0;
            end
            default: begin
                timer_hit    = 1'b0;
                timer_rvalue = 32'h0;
            end
        endcase
    end

    assign timer_int = r_timer_int;
    assign tid       = r_tid;

    stable_counter #(
        .W (CNT_W)
    ) u_stable_counter (
        .clk    (clk),
        .resetn (resetn),
        .cnt_lo (cnt_vl),
        .cnt_hi (cnt_vh)
    );

endmodule
`default_nettype wire

// File: tb/tb_csr_timer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_csr_timer
//  Description : Self-checking bench for csr_timer: reset/read table,
//                one-shot, periodic, clear/set collision, masked writes,
//                asynchronous reset mid-count and an 8-bit counter wrap.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_csr_timer;

    localparam logic [31:0] c_tid_reset = 32'h5A5A_1234;
    localparam logic [13:0] c_tid   = 14'h040;
    localparam logic [13:0] c_tcfg  = 14'h041;
    localparam logic [13:0] c_tval  = 14'h042;
    localparam logic [13:0] c_ticlr = 14'h044;

    logic        clk = 1'b0;
    logic        resetn = 1'b0;
    logic        csr_we = 1'b0;
    logic [13:0] csr_num = 14'h0;
    logic [31:0] csr_wmask = 32'h0;
    logic [31:0] csr_wvalue = 32'h0;

    logic        timer_hit, timer_int;
    logic [31:0] timer_rvalue, cnt_vl, cnt_vh, tid;

    logic        timer_hit8, timer_int8;
    logic [31:0] timer_rvalue8, cnt_vl8, cnt_vh8, tid8;

    always #5 clk = ~clk;

    csr_timer #(.TID_RESET(c_tid_reset), .CNT_W(64)) dut (
        .clk(clk), .resetn(resetn), .csr_we(csr_we), .csr_num(csr_num),
        .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue),
        .timer_hit(timer_hit), .timer_rvalue(timer_rvalue),
        .timer_int(timer_int), .cnt_vl(cnt_vl), .cnt_vh(cnt_vh), .tid(tid)
    );

    csr_timer #(.TID_RESET(c_tid_reset), .CNT_W(8)) dut8 (
        .clk(clk), .resetn(resetn), .csr_we(csr_we), .csr_num(csr_num),
        .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue),
        .timer_hit(timer_hit8), .timer_rvalue(timer_rvalue8),
        .timer_int(timer_int8), .cnt_vl(cnt_vl8), .cnt_vh(cnt_vh8), .tid(tid8)
    );

    typedef struct {
        logic [13:0] num;
        logic        hit;
        logic [31:0] rv;
    } rd_vec_t;

    typedef struct {
        logic [31:0] tval;
        logic        irq;
    } sb_t;

    sb_t sb[$];
    int  n_cmp = 0;
    int  n_err = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [13:0] num, input logic [31:0] m, input logic [31:0] v);
        csr_we = 1'b1; csr_num = num; csr_wmask = m; csr_wvalue = v;
    endtask

    // One clock: inputs return to an idle TVAL read just after the edge
    task automatic tick();
        @(posedge clk);
        #1;
        csr_we = 1'b0; csr_num = c_tval; csr_wmask = 32'h0; csr_wvalue = 32'h0;
        #1;
    endtask

    // One clock, then pop the scoreboard and compare TVAL / timer_int
    task automatic step(input string name);
        sb_t e;
        tick();
        if (sb.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL %s: scoreboard empty", name);
        end else begin
            e = sb.pop_front();
            check({name, "_tval"}, {32'h0, timer_rvalue}, {32'h0, e.tval});
            check({name, "_int"}, {63'h0, timer_int}, {63'h0, e.irq});
        end
    endtask

    task automatic read_chk(input string name, input logic [13:0] num, input logic [31:0] exp);
        csr_num = num;
        #1;
        check(name, {32'h0, timer_rvalue}, {32'h0, exp});
    endtask

    rd_vec_t rd_tbl[6];
    int      guard;
    logic    irq_exp;

    initial begin
        rd_tbl[0] = '{num: c_tid,   hit: 1'b1, rv: c_tid_reset};
        rd_tbl[1] = '{num: c_tcfg,  hit: 1'b1, rv: 32'h0};
        rd_tbl[2] = '{num: c_tval,  hit: 1'b1, rv: 32'hFFFF_FFFF};
        rd_tbl[3] = '{num: c_ticlr, hit: 1'b1, rv: 32'h0};
        rd_tbl[4] = '{num: 14'h043, hit: 1'b0, rv: 32'h0};
        rd_tbl[5] = '{num: 14'h000, hit: 1'b0, rv: 32'h0};

        // ---- 1. reset and read-back ----
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        #1;
        check("rst_int", {63'h0, timer_int}, 64'h0);
        check("rst_cnt", {cnt_vh, cnt_vl}, 64'h0);
        for (int i = 0; i < 6; i++) begin
            csr_num = rd_tbl[i].num;
            #1;
            check($sformatf("rd_hit_%0d", i), {63'h0, timer_hit}, {63'h0, rd_tbl[i].hit});
            check($sformatf("rd_val_%0d", i), {32'h0, timer_rvalue}, {32'h0, rd_tbl[i].rv});
        end
        tick();
        check("cnt_1", {cnt_vh, cnt_vl}, 64'h1);
        tick();
        check("cnt_2", {cnt_vh, cnt_vl}, 64'h2);

        // ---- 2. one-shot, InitVal=4 ----
        for (int i = 1; i <= 20; i++) begin
            if (i == 1) drive(c_tcfg, 32'hFFFF_FFFF, 32'h0000_0011);
            sb.push_back('{tval: (i <= 17) ? 32'(17 - i) : 32'hFFFF_FFFF, irq: (i >= 18)});
            step($sformatf("oneshot_%0d", i));
        end
        drive(c_ticlr, 32'h1, 32'h1);
        sb.push_back('{tval: 32'hFFFF_FFFF, irq: 1'b0});
        step("oneshot_clr");

        // ---- 3/4. periodic, InitVal=2; clears at TVAL=8 and at TVAL=0 ----
        for (int i = 1; i <= 40; i++) begin
            if (i == 1) drive(c_tcfg, 32'hFFFF_FFFF, 32'h0000_000B);
            if (i == 20 || i == 29 || i == 37) drive(c_ticlr, 32'h1, 32'h1);
            irq_exp = (i >= 10) && !(i >= 20 && i <= 27) && !(i >= 29 && i <= 36);
            sb.push_back('{tval: 32'(8 - ((i - 1) % 9)), irq: irq_exp});
            step($sformatf("periodic_%0d", i));
        end

        // ---- 5. masked writes ----
        drive(c_tcfg, 32'h1, 32'h0);
        sb.push_back('{tval: 32'd5, irq: 1'b1});
        step("freeze_0");
        sb.push_back('{tval: 32'd5, irq: 1'b1});
        step("freeze_1");
        read_chk("tcfg_masked", c_tcfg, 32'h0000_000A);
        drive(c_tval, 32'hFFFF_FFFF, 32'h0000_1234);
        sb.push_back('{tval: 32'd5, irq: 1'b1});
        step("tval_ro");
        drive(c_tid, 32'h0000_00FF, 32'h0000_00AB);
        sb.push_back('{tval: 32'd5, irq: 1'b1});
        step("tid_wr");
        check("tid_port", {32'h0, tid}, {32'h0, (c_tid_reset & ~32'hFF) | 32'hAB});
        read_chk("tid_read", c_tid, (c_tid_reset & ~32'hFF) | 32'hAB);
        read_chk("ticlr_read", c_ticlr, 32'h0);

        // ---- reset asserted mid-cycle ----
        @(posedge clk);
        #3 resetn = 1'b0;
        #1;
        check("arst_int", {63'h0, timer_int}, 64'h0);
        check("arst_cnt", {cnt_vh, cnt_vl}, 64'h0);
        check("arst_tid", {32'h0, tid}, {32'h0, c_tid_reset});
        read_chk("arst_tval", c_tval, 32'hFFFF_FFFF);
        read_chk("arst_tcfg", c_tcfg, 32'h0);
        @(posedge clk);
        #1 resetn = 1'b1;
        #1;
        check("rel_cnt0", {cnt_vh, cnt_vl}, 64'h0);
        tick();
        check("rel_cnt1", {cnt_vh, cnt_vl}, 64'h1);

        // ---- 6. 8-bit counter wrap ----
        guard = 0;
        while (cnt_vl8 != 32'hFF && guard < 300) begin
            tick();
            guard++;
        end
        if (guard >= 300) begin
            n_cmp++; n_err++;
            $display("FAIL wrap_wait: got %0h expected ff", cnt_vl8);
        end
        check("wrap_pre_vh", {32'h0, cnt_vh8}, 64'h0);
        tick();
        check("wrap_vl", {32'h0, cnt_vl8}, 64'h0);
        check("wrap_vh", {32'h0, cnt_vh8}, 64'h0);
        check("wide_no_wrap", {cnt_vh, cnt_vl}, 64'h100);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
